dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between the pipeline MEM stage (CPU) and a debug/loader port (DBG).
//  Sits between the EX/MEM pipeline register and datamemory.
//  The CPU has priority and zero added latency. DBG is served in idle MEM cycles.
//  A starvation counter lets DBG steal one cycle, stalling the pipeline.
// PARAMETERS
//  DATA_W      32  data width
//  DM_ADDRESS  9   byte address width of data memory
//  MAX_WAIT    8   DBG wait cycles before a forced steal (>=1)
// PORTS
//  clk         in   1        clock, rising edge
//  reset       in   1        asynchronous, active-low reset
//  cpu_req     in   1        MEM stage access (MemRead|MemWrite)
//  cpu_we      in   1        1=store, 0=load
//  cpu_addr    in   DM_ADDRESS  ALU result address
//  cpu_wdata   in   DATA_W   store data
//  cpu_funct3  in   3        access size/sign
//  cpu_rdata   out  DATA_W   load data to MEM/WB
//  cpu_stall   out  1        hold PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
//  dbg_valid   in   1        DBG request pending
//  dbg_ready   out  1        DBG request accepted this cycle
//  dbg_we      in   1        1=write, 0=read
//  dbg_addr    in   DM_ADDRESS  DBG address (word aligned)
//  dbg_wdata   in   DATA_W   DBG write data
//  dbg_rvalid  out  1        DBG read data valid (1-cycle pulse)
//  dbg_rdata   out  DATA_W   DBG read data
//  mem_rd, mem_wr  out  1    datamemory strobes
//  mem_addr    out  DM_ADDRESS; mem_wdata out DATA_W; mem_funct3 out 3
//  mem_rdata   in   DATA_W   datamemory read data (combinational)
// BEHAVIOUR
//  Reset state: state=CPU, wait_cnt=0. dbg_rvalid, dbg_rdata, mem_rd, mem_wr and cpu_stall are all 0.
//  States: CPU, STEAL, COOL.
//   CPU:
//    - cpu_req=1: mem_* = cpu_* (combinational pass-through, 0 latency).
//    - cpu_req=0 && dbg_valid: DBG granted, dbg_ready=1, wait_cnt<=0.
//    - cpu_req=1 && dbg_valid: wait_cnt++ (saturating). At wait_cnt==MAX_WAIT-1 -> STEAL.
//   STEAL:
//    - DBG granted unconditionally. dbg_ready=1.
//    - cpu_stall=cpu_req; the CPU request re-presents next cycle.
//    - wait_cnt<=0. Next state COOL.
//    - If dbg_valid has dropped: no access, cpu_stall=0, -> CPU.
//   COOL: one cycle; behaves as CPU but DBG may only be granted if cpu_req=0 and the counter is held. -> CPU.
//  DBG grant: mem_funct3=3'b010 (word); dbg_addr[1:0] ignored.
//  DBG read: mem_rdata is registered at the grant edge; dbg_rvalid=1 and dbg_rdata valid the next cycle.
//  cpu_rdata = mem_rdata always; only meaningful when a CPU access is granted.
//  cpu_stall is only ever 1 in STEAL, and for at most 1 cycle per MAX_WAIT+1 cycles.
//  Simultaneous events:
//   - dbg_valid falling in the counting cycle resets wait_cnt to 0.
//   - dbg_ready and cpu_stall never both 1 unless in STEAL.
//  Reset mid-operation: all outputs are forced to their reset values immediately. An in-flight DBG read is dropped (no dbg_rvalid).
//  DBG handshake: the requester holds dbg_* stable while dbg_valid=1 && dbg_ready=0.
// STRUCTURE
//  The shared package (Pipe_Buf_Reg_PKG or a sibling) holds:
//   - typedef enum logic[1:0] {ARB_CPU, ARB_STEAL, ARB_COOL} arb_state_t
//   - localparam FUNCT3_WORD = 3'b010
//  Sub-module: starve_counter (saturating wait counter with clear/inc/hit).
//  The rest is one FSM plus an output mux.
// TESTING
//  1. reset=0 for 2 cycles, then 1 -> all outputs 0, state CPU.
//  2. cpu_req=0, DBG write 0xDEADBEEF @0x40 -> dbg_ready=1 same cycle.
//     Then a DBG read @0x40 -> dbg_rvalid=1 one cycle later with 0xDEADBEEF.
//  3. cpu_req=1 for 20 cycles with dbg_valid=1, MAX_WAIT=8:
//     - steal on cycle 8 with cpu_stall=1 for exactly 1 cycle;
//     - the next steal comes no earlier than 8 cycles later.
//  4. CPU store 0x12 (funct3=000) @0x05 while dbg_valid=0 -> mem_* mirrors cpu_*.
//     A later CPU load returns 0x12 with no stall.
//  5. DBG read granted, reset asserted before the next edge -> no dbg_rvalid; counter 0.
//  6. dbg_valid deasserted in the STEAL cycle -> no memory strobe, cpu_stall=0, state CPU.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_CPU   = 2'd0,
        ARB_STEAL = 2'd1,
        ARB_COOL  = 2'd2
    } arb_state_t;

    // Debug accesses are always full words.
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// Starvation counter: counts cycles the debug port has waited behind the CPU.
// Saturates at MAX_WAIT-1, where o_hit asserts; clear has priority over increment.
module dmem_port_arbiter_starve_counter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc && (r_cnt != HIT_VAL)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_hit = (r_cnt == HIT_VAL);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage owns the port with zero added latency;
// the debug/loader port uses idle cycles and may steal one cycle after waiting too long.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    // CPU MEM stage
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [DM_ADDRESS-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0]     i_cpu_wdata,
    input  logic [2:0]            i_cpu_funct3,
    output logic [DATA_W-1:0]     o_cpu_rdata,
    output logic                  o_cpu_stall,
    // Debug / loader port
    input  logic                  i_dbg_valid,
    output logic                  o_dbg_ready,
    input  logic                  i_dbg_we,
    input  logic [DM_ADDRESS-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0]     i_dbg_wdata,
    output logic                  o_dbg_rvalid,
    output logic [DATA_W-1:0]     o_dbg_rdata,
    // Data memory
    output logic                  o_mem_rd,
    output logic                  o_mem_wr,
    output logic [DM_ADDRESS-1:0] o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [2:0]            o_mem_funct3,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam logic [DM_ADDRESS-1:0] WORD_MASK = ~DM_ADDRESS'(3);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic              w_stall;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_hit;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    dmem_port_arbiter_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_hit   (w_hit)
    );

    // Arbitration FSM: grant selection, stall and starvation-counter control.
    always_comb begin
        w_state_nxt = r_state;
        w_cpu_gnt   = 1'b0;
        w_dbg_gnt   = 1'b0;
        w_stall     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ARB_CPU: begin
                if (i_cpu_req) begin
                    w_cpu_gnt = 1'b1;
                    if (i_dbg_valid) begin
                        w_cnt_inc = 1'b1;
                        if (w_hit) begin
                            w_state_nxt = ARB_STEAL;
                        end
                    end else begin
                        w_cnt_clr = 1'b1;
                    end
                end else begin
                    w_dbg_gnt = i_dbg_valid;
                    w_cnt_clr = 1'b1;
                end
            end
            ARB_STEAL: begin
                // A withdrawn debug request leaves this cycle with no access at all.
                w_cnt_clr   = 1'b1;
                w_dbg_gnt   = i_dbg_valid;
                w_stall     = i_dbg_valid & i_cpu_req;
                w_state_nxt = i_dbg_valid ? ARB_COOL : ARB_CPU;
            end
            ARB_COOL: begin
                // Counter holds here so a steal cannot immediately repeat.
                w_state_nxt = ARB_CPU;
                if (i_cpu_req) begin
                    w_cpu_gnt = 1'b1;
                end else begin
                    w_dbg_gnt = i_dbg_valid;
                end
            end
            default: begin
                w_state_nxt = ARB_CPU;
            end
        endcase
        // Reset forces all handshake/strobe outputs low immediately.
        if (!i_rst_n) begin
            w_cpu_gnt = 1'b0;
            w_dbg_gnt = 1'b0;
            w_stall   = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ARB_CPU;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory port mux: CPU pass-through by default, debug word access when granted.
    always_comb begin
        o_mem_addr   = i_cpu_addr;
        o_mem_wdata  = i_cpu_wdata;
        o_mem_funct3 = i_cpu_funct3;
        o_mem_rd     = w_cpu_gnt & ~i_cpu_we;
        o_mem_wr     = w_cpu_gnt & i_cpu_we;
        if (w_dbg_gnt) begin
            o_mem_addr   = i_dbg_addr & WORD_MASK;
            o_mem_wdata  = i_dbg_wdata;
            o_mem_funct3 = FUNCT3_WORD;
            o_mem_rd     = ~i_dbg_we;
            o_mem_wr     = i_dbg_we;
        end
    end

    // Capture debug read data at the grant edge; rvalid pulses the following cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_dbg_gnt & ~i_dbg_we;
            if (w_dbg_gnt && !i_dbg_we) begin
                r_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_cpu_rdata  = i_mem_rdata;
    assign o_cpu_stall  = w_stall;
    assign o_dbg_ready  = w_dbg_gnt;
    assign o_dbg_rvalid = r_rvalid;
    assign o_dbg_rdata  = r_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a byte-addressed memory model.
module tb_dmem_port_arbiter;

    localparam int DATA_W     = 32;
    localparam int DM_ADDRESS = 9;
    localparam int MAX_WAIT   = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [DM_ADDRESS-1:0] cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [2:0]            cpu_funct3;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_stall;
    logic                  dbg_valid;
    logic                  dbg_ready;
    logic                  dbg_we;
    logic [DM_ADDRESS-1:0] dbg_addr;
    logic [DATA_W-1:0]     dbg_wdata;
    logic                  dbg_rvalid;
    logic [DATA_W-1:0]     dbg_rdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_funct3;
    logic [DATA_W-1:0]     mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:511];

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .DATA_W     (DATA_W),
        .DM_ADDRESS (DM_ADDRESS),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .i_cpu_funct3 (cpu_funct3),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_stall  (cpu_stall),
        .i_dbg_valid  (dbg_valid),
        .o_dbg_ready  (dbg_ready),
        .i_dbg_we     (dbg_we),
        .i_dbg_addr   (dbg_addr),
        .i_dbg_wdata  (dbg_wdata),
        .o_dbg_rvalid (dbg_rvalid),
        .o_dbg_rdata  (dbg_rdata),
        .o_mem_rd     (mem_rd),
        .o_mem_wr     (mem_wr),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_funct3 (mem_funct3),
        .i_mem_rdata  (mem_rdata)
    );

    // Combinational data memory: byte loads (signed/unsigned) and word loads.
    always_comb begin
        int a;
        int b;
        a = int'(mem_addr) & ~3;
        b = int'(mem_addr);
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{mem[b][7]}}, mem[b]};
            3'b100:  mem_rdata = {24'd0, mem[b]};
            default: mem_rdata = {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        endcase
    end

    // Memory writes: byte or word.
    always @(posedge clk) begin
        if (mem_wr) begin
            if (mem_funct3[1:0] == 2'b00) begin
                mem[int'(mem_addr)] <= mem_wdata[7:0];
            end else begin
                mem[(int'(mem_addr) & ~3) + 0] <= mem_wdata[7:0];
                mem[(int'(mem_addr) & ~3) + 1] <= mem_wdata[15:8];
                mem[(int'(mem_addr) & ~3) + 2] <= mem_wdata[23:16];
                mem[(int'(mem_addr) & ~3) + 3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        cpu_funct3 = 3'b010;
        dbg_valid  = 1'b0;
        dbg_we     = 1'b0;
        dbg_addr   = '0;
        dbg_wdata  = '0;
    endtask

    // Holds CPU load @0x10 against a DBG read @0x40; returns index of first stalled cycle.
    task automatic run_contention(input int max_cyc, output int first);
        first      = -1;
        cpu_req    = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 9'h010;
        cpu_funct3 = 3'b010;
        dbg_valid  = 1'b1;
        dbg_we     = 1'b0;
        dbg_addr   = 9'h040;
        for (int i = 0; i < max_cyc; i++) begin
            #1;
            if (cpu_stall && first < 0) first = i;
            step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n     = 1'b0;
        cpu_req   = 1'b1;
        dbg_valid = 1'b1;
        step();
        step();
        n_checks++;
        if (mem_rd !== 1'b0 || dbg_ready !== 1'b0 || cpu_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_gating: rd=%b ready=%b stall=%b required 0 0 0",
                     mem_rd, dbg_ready, cpu_stall);
        end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({mem_rd, mem_wr, cpu_stall, dbg_ready, dbg_rvalid} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: rd/wr/stall/ready/rvalid=%b required 00000",
                     {mem_rd, mem_wr, cpu_stall, dbg_ready, dbg_rvalid});
        end
        n_checks++;
        if (dbg_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_rdata: got %h required 00000000", dbg_rdata);
        end
        step();
    endtask

    task automatic test_dbg_idle();
        dbg_valid = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 9'h040;
        dbg_wdata = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (dbg_ready !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 9'h040 ||
            mem_funct3 !== 3'b010 || mem_wdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL dbg_write: ready=%b wr=%b addr=%h f3=%b wdata=%h required 1 1 040 010 deadbeef",
                     dbg_ready, mem_wr, mem_addr, mem_funct3, mem_wdata);
        end
        step();
        dbg_we   = 1'b0;
        dbg_addr = 9'h043;
        #1;
        n_checks++;
        if (dbg_ready !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 9'h040 ||
            dbg_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL dbg_read_grant: ready=%b rd=%b addr=%h rvalid=%b required 1 1 040 0",
                     dbg_ready, mem_rd, mem_addr, dbg_rvalid);
        end
        step();
        dbg_valid = 1'b0;
        #1;
        n_checks++;
        if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL dbg_read_data: rvalid=%b rdata=%h required 1 deadbeef",
                     dbg_rvalid, dbg_rdata);
        end
        step();
        n_checks++;
        if (dbg_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL dbg_rvalid_pulse: got %b required 0", dbg_rvalid);
        end
    endtask

    task automatic test_steal();
        logic                  exp_stall;
        logic [DM_ADDRESS-1:0] exp_addr;
        cpu_req    = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 9'h010;
        cpu_funct3 = 3'b010;
        dbg_valid  = 1'b1;
        dbg_we     = 1'b0;
        dbg_addr   = 9'h040;
        // Steals expected on cycles 8 and 18 (steal, cool, then 8 waiting cycles).
        for (int i = 0; i < 20; i++) begin
            exp_stall = (i == 8 || i == 18);
            exp_addr  = exp_stall ? 9'h040 : 9'h010;
            #1;
            n_checks++;
            if (cpu_stall !== exp_stall || dbg_ready !== exp_stall) begin
                n_errors++;
                $display("FAIL steal_cycle%0d: stall=%b ready=%b required %b %b",
                         i, cpu_stall, dbg_ready, exp_stall, exp_stall);
            end
            n_checks++;
            if (mem_addr !== exp_addr || mem_rd !== 1'b1) begin
                n_errors++;
                $display("FAIL steal_addr%0d: addr=%h rd=%b required %h 1",
                         i, mem_addr, mem_rd, exp_addr);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_cpu_access();
        cpu_req    = 1'b1;
        cpu_we     = 1'b1;
        cpu_addr   = 9'h005;
        cpu_wdata  = 32'h00000012;
        cpu_funct3 = 3'b000;
        #1;
        n_checks++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 9'h005 ||
            mem_wdata !== 32'h12 || mem_funct3 !== 3'b000 || cpu_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL cpu_store: wr=%b rd=%b addr=%h wdata=%h f3=%b stall=%b",
                     mem_wr, mem_rd, mem_addr, mem_wdata, mem_funct3, cpu_stall);
        end
        step();
        cpu_req    = 1'b0;
        step();
        cpu_req    = 1'b1;
        cpu_we     = 1'b0;
        cpu_funct3 = 3'b100;
        #1;
        n_checks++;
        if (cpu_rdata !== 32'h00000012 || mem_rd !== 1'b1 || cpu_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL cpu_load: rdata=%h rd=%b stall=%b required 00000012 1 0",
                     cpu_rdata, mem_rd, cpu_stall);
        end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        int first;
        // Read granted, then reset before the capturing edge.
        dbg_valid = 1'b1;
        dbg_we    = 1'b0;
        dbg_addr  = 9'h040;
        #1;
        n_checks++;
        if (dbg_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rst_mid_grant: ready=%b required 1", dbg_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dbg_ready !== 1'b0 || mem_rd !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_force: ready=%b rd=%b required 0 0", dbg_ready, mem_rd);
        end
        step();
        idle_inputs();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (dbg_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_rvalid: got %b required 0", dbg_rvalid);
        end
        step();
        n_checks++;
        if (dbg_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_rvalid2: got %b required 0", dbg_rvalid);
        end
        // Partially filled counter must be cleared by reset.
        run_contention(5, first);
        n_checks++;
        if (first !== -1) begin
            n_errors++;
            $display("FAIL rst_cnt_preload: first stall %0d required -1", first);
        end
        #2;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run_contention(12, first);
        n_checks++;
        if (first !== 8) begin
            n_errors++;
            $display("FAIL rst_cnt_cleared: first stall %0d required 8", first);
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_steal_abort();
        int first;
        run_contention(8, first);
        n_checks++;
        if (first !== -1) begin
            n_errors++;
            $display("FAIL abort_pre: first stall %0d required -1", first);
        end
        // Now in the steal cycle; the debug request is withdrawn.
        dbg_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || cpu_stall !== 1'b0 || dbg_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_steal: rd=%b wr=%b stall=%b ready=%b required 0 0 0 0",
                     mem_rd, mem_wr, cpu_stall, dbg_ready);
        end
        step();
        // Back in CPU with a cleared counter: next steal after exactly MAX_WAIT cycles.
        run_contention(12, first);
        n_checks++;
        if (first !== 8) begin
            n_errors++;
            $display("FAIL abort_state_cpu: first stall %0d required 8", first);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #1;
        test_reset();
        test_dbg_idle();
        test_steal();
        test_cpu_access();
        test_reset_mid();
        test_steal_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
